// File: rtl/text_mode_renderer.sv
// text_mode_renderer: converts raster coordinates into RGB888 pixels for an
// 80x30 text screen of 8x16 cells (8x8 glyphs, each glyph row shown twice).
// Reads char/attr RAM and the font ROM, overlays a blinking underline cursor,
// and delays sync/DE so every output lines up with its pixel (3 clk latency).
//
// Ports
//   clk, rst                        pixel clock, synchronous active-high reset
//   pix_x, pix_y, pix_de            raster position and active-video flag
//   pix_hsync, pix_vsync            syncs from the timing generator
//   video_char_addr                 char/attr RAM address (combinational)
//   video_char_data, video_attr_data RAM read data, valid 1 clk after address
//   font_addr                       {char_code, glyph_row} (combinational)
//   font_data                       glyph row, valid 1 clk after font_addr
//   cursor_en, cursor_x, cursor_y   cursor overlay control
//   rgb_r, rgb_g, rgb_b             pixel colour
//   out_de, out_hsync, out_vsync    delayed DE/syncs aligned with rgb
module text_mode_renderer #(
   parameter int unsigned COLS         = 80,
   parameter int unsigned ROWS         = 30,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        pix_de,
   input  logic        pix_hsync,
   input  logic        pix_vsync,
   output logic [11:0] video_char_addr,
   input  logic [7:0]  video_char_data,
   input  logic [7:0]  video_attr_data,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   input  logic        cursor_en,
   input  logic [6:0]  cursor_x,
   input  logic [4:0]  cursor_y,
   output logic [7:0]  rgb_r,
   output logic [7:0]  rgb_g,
   output logic [7:0]  rgb_b,
   output logic        out_de,
   output logic        out_hsync,
   output logic        out_vsync
);

   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   // CGA 16-colour palette
   function automatic logic [23:0] cga(input logic [3:0] idx);
      logic [23:0] c;
      case (idx)
         4'h0:    c = 24'h000000;
         4'h1:    c = 24'h0000AA;
         4'h2:    c = 24'h00AA00;
         4'h3:    c = 24'h00AAAA;
         4'h4:    c = 24'hAA0000;
         4'h5:    c = 24'hAA00AA;
         4'h6:    c = 24'hAA5500;
         4'h7:    c = 24'hAAAAAA;
         4'h8:    c = 24'h555555;
         4'h9:    c = 24'h5555FF;
         4'hA:    c = 24'h55FF55;
         4'hB:    c = 24'h55FFFF;
         4'hC:    c = 24'hFF5555;
         4'hD:    c = 24'hFF55FF;
         4'hE:    c = 24'hFFFF55;
         default: c = 24'hFFFFFF;
      endcase
      return c;
   endfunction

   // blink state
   logic       vs_prev_q;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       blink_phase_q, blink_phase_d;

   // S1 side-signal registers
   logic [2:0] s1_x_lo_q, s1_grow_q;
   logic       s1_hit_q, s1_de_q, s1_hs_q, s1_vs_q;

   // S2 registers
   logic [7:0] s2_attr_q;
   logic [2:0] s2_x_lo_q;
   logic       s2_hit_q, s2_de_q, s2_hs_q, s2_vs_q;

   // S3 output register
   logic [23:0] rgb_q, rgb_d;

   // S0 cell decode
   logic [6:0]  col_c;
   logic [5:0]  row_c;
   logic        in_range_c;
   logic [11:0] lin_addr_c;
   logic        cursor_hit_c;

   // S0: cell address and cursor hit; the hit already folds in line 14/15
   // and the blink phase so only one bit needs to travel down the pipe.
   always_comb begin
      col_c           = pix_x[9:3];
      row_c           = pix_y[9:4];
      in_range_c      = (32'(col_c) < COLS) && (32'(row_c) < ROWS);
      lin_addr_c      = {row_c, 6'b0} + 12'({row_c, 4'b0}) + 12'(col_c);
      video_char_addr = in_range_c ? lin_addr_c : 12'hFFF;
      cursor_hit_c    = cursor_en && blink_phase_q &&
                        (col_c == cursor_x) && (row_c == 6'(cursor_y)) &&
                        ((pix_y[3:0] == 4'd14) || (pix_y[3:0] == 4'd15));
   end

   // Font ROM address uses RAM data directly; it arrives alongside S1 regs.
   assign font_addr = {video_char_data, s1_grow_q};

   // Frame counter / blink phase, advanced on each vsync rising edge
   always_comb begin
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      if (pix_vsync && !vs_prev_q) begin
         if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d   = 8'd0;
            blink_phase_d = !blink_phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   // S3: pixel select, cursor override and blanking
   always_comb begin
      logic       pix_on;
      logic [3:0] idx;
      pix_on = font_data[3'd7 - s2_x_lo_q];
      idx    = (pix_on || s2_hit_q) ? s2_attr_q[3:0] : s2_attr_q[7:4];
      rgb_d  = s2_de_q ? cga(idx) : 24'h000000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev_q     <= 1'b0;
         frame_cnt_q   <= 8'd0;
         blink_phase_q <= 1'b1;
         s1_x_lo_q     <= 3'd0;
         s1_grow_q     <= 3'd0;
         s1_hit_q      <= 1'b0;
         s1_de_q       <= 1'b0;
         s1_hs_q       <= 1'b0;
         s1_vs_q       <= 1'b0;
         s2_attr_q     <= 8'd0;
         s2_x_lo_q     <= 3'd0;
         s2_hit_q      <= 1'b0;
         s2_de_q       <= 1'b0;
         s2_hs_q       <= 1'b0;
         s2_vs_q       <= 1'b0;
         rgb_q         <= 24'd0;
         out_de        <= 1'b0;
         out_hsync     <= 1'b0;
         out_vsync     <= 1'b0;
      end else begin
         vs_prev_q     <= pix_vsync;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         s1_x_lo_q     <= pix_x[2:0];
         s1_grow_q     <= pix_y[3:1];
         s1_hit_q      <= cursor_hit_c;
         s1_de_q       <= pix_de;
         s1_hs_q       <= pix_hsync;
         s1_vs_q       <= pix_vsync;
         s2_attr_q     <= video_attr_data;
         s2_x_lo_q     <= s1_x_lo_q;
         s2_hit_q      <= s1_hit_q;
         s2_de_q       <= s1_de_q;
         s2_hs_q       <= s1_hs_q;
         s2_vs_q       <= s1_vs_q;
         rgb_q         <= rgb_d;
         out_de        <= s2_de_q;
         out_hsync     <= s2_hs_q;
         out_vsync     <= s2_vs_q;
      end
   end

   assign rgb_r = rgb_q[23:16];
   assign rgb_g = rgb_q[15:8];
   assign rgb_b = rgb_q[7:0];

endmodule
